dadda_multiplier_iterative: RTL

//   Parametrised multi-cycle unsigned multiplier, optionally signed, with valid/ready handshakes on input and output.

---
 rtl/dadda_multiplier_iterative.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/dadda_multiplier_iterative.sv
// Multi-cycle shift-and-add multiplier retiring BITS_PER_CYCLE multiplier bits per clock.
// Optional two's-complement mode is enabled by defining DADDA_MUL_SIGNED_EN.
module dadda_multiplier_iterative #(
    parameter int WIDTH          = 64,
    parameter int BITS_PER_CYCLE = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
`ifdef DADDA_MUL_SIGNED_EN
    input  logic                 is_signed,
`endif
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int N     = WIDTH / BITS_PER_CYCLE;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam int SH_W  = $clog2(2 * WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state_r;
    logic [WIDTH-1:0]     a_reg_r;
    logic [WIDTH-1:0]     b_reg_r;
    logic [2*WIDTH-1:0]   acc_r;
    logic [CNT_W-1:0]     cnt_r;
    logic                 neg_r;

    logic [WIDTH-1:0]     a_mag_s;
    logic [WIDTH-1:0]     b_mag_s;
    logic                 neg_s;
    logic [2*WIDTH-1:0]   pp_s;
    logic [SH_W-1:0]      shift_s;
    logic [2*WIDTH-1:0]   sum_s;
    logic [2*WIDTH-1:0]   result_s;
    logic                 last_s;

    // Two's-complement magnitude; the most negative value maps onto its unsigned twin.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sg);
        if (sg && v[WIDTH-1]) begin
            magnitude = -v;
        end else begin
            magnitude = v;
        end
    endfunction

    // Operand conditioning at accept time.
    always_comb begin
        a_mag_s = a;
        b_mag_s = b;
        neg_s   = 1'b0;
`ifdef DADDA_MUL_SIGNED_EN
        a_mag_s = magnitude(a, is_signed);
        b_mag_s = magnitude(b, is_signed);
        neg_s   = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
`endif
    end

    // One digit step: partial product, alignment and running sum.
    always_comb begin
        pp_s     = {{WIDTH{1'b0}}, a_reg_r}
                 * {{(2*WIDTH-BITS_PER_CYCLE){1'b0}}, b_reg_r[BITS_PER_CYCLE-1:0]};
        shift_s  = SH_W'(cnt_r) * SH_W'(BITS_PER_CYCLE);
        sum_s    = acc_r + (pp_s << shift_s);
        last_s   = (cnt_r == CNT_W'(N - 1));
        if (neg_r) begin
            result_s = -sum_s;
        end else begin
            result_s = sum_s;
        end
    end

    // Control FSM with registered handshake outputs and datapath state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= S_IDLE;
            a_reg_r   <= '0;
            b_reg_r   <= '0;
            acc_r     <= '0;
            cnt_r     <= '0;
            neg_r     <= 1'b0;
            product   <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        a_reg_r  <= a_mag_s;
                        b_reg_r  <= b_mag_s;
                        neg_r    <= neg_s;
                        acc_r    <= '0;
                        cnt_r    <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state_r  <= S_BUSY;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                S_BUSY: begin
                    acc_r   <= sum_s;
                    b_reg_r <= b_reg_r >> BITS_PER_CYCLE;
                    cnt_r   <= cnt_r + CNT_W'(1);
                    if (last_s) begin
                        product   <= result_s;
                        out_valid <= 1'b1;
                        state_r   <= S_DONE;
                    end else begin
                        state_r   <= S_BUSY;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        state_r   <= S_IDLE;
                    end else begin
                        state_r   <= S_DONE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    in_ready  <= 1'b0;
                    state_r   <= S_IDLE;
                end
            endcase
        end
    end

endmodule
